// File: rtl/modn_down_timer.sv
// Loadable mod-N down counter / timer with one-shot and auto-reload modes.
// Emits a registered one-cycle done pulse on the edge that leaves count 0.
module modn_down_timer #(
   parameter int M = 3,
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         start,
   input  logic         load,
   input  logic [M-1:0] load_val,
   input  logic         auto_reload,
   output logic [M-1:0] out,
   output logic         done,
   output logic         busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [M-1:0] RST_VAL = M'(N);

   state_t       state;
   logic [M-1:0] reload_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         reload_reg <= RST_VAL;
         out        <= RST_VAL;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            // load wins over any decrement or terminal event this edge
            reload_reg <= load_val;
            out        <= load_val;
            if (state == IDLE && start) begin
               state <= RUN;
               busy  <= 1'b1;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
               RUN: begin
                  if (en) begin
                     if (out == '0) begin
                        out  <= reload_reg;
                        done <= 1'b1;
                        if (!auto_reload) begin
                           state <= IDLE;
                           busy  <= 1'b0;
                        end
                     end else begin
                        out <= out - 1'b1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_modn_down_timer.sv
// Directed bench for modn_down_timer: expected outputs queued per step,
// popped and checked one delta after the following rising edge.
module tb_modn_down_timer;

   typedef struct packed {
      logic [2:0] o;
      logic       d;
      logic       b;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       start = 1'b0;
   logic       load = 1'b0;
   logic [2:0] load_val = '0;
   logic       auto_reload = 1'b0;
   logic [2:0] out;
   logic       done;
   logic       busy;

   exp_t q[$];
   int   total  = 0;
   int   passed = 0;

   modn_down_timer #(.M(3), .N(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .start       (start),
      .load        (load),
      .load_val    (load_val),
      .auto_reload (auto_reload),
      .out         (out),
      .done        (done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic step(
      input logic       r,
      input logic       st,
      input logic       e,
      input logic       ld,
      input logic [2:0] lv,
      input logic       ar,
      input logic [2:0] eo,
      input logic       ed,
      input logic       eb,
      input string      tag
   );
      exp_t x;
      @(negedge clk);
      reset       = r;
      start       = st;
      en          = e;
      load        = ld;
      load_val    = lv;
      auto_reload = ar;
      q.push_back('{o: eo, d: ed, b: eb});
      @(posedge clk);
      #1;
      x = q.pop_front();
      total++;
      assert (out === x.o && done === x.d && busy === x.b) passed++;
      else $error("FAIL %s: out=%0d done=%0b busy=%0b expected out=%0d done=%0b busy=%0b",
                  tag, out, done, busy, x.o, x.d, x.b);
   endtask

   initial begin
      // reset state
      step(1, 0, 0, 0, 0, 0, 5, 0, 0, "reset");
      // one-shot countdown from N
      step(0, 1, 1, 0, 0, 0, 5, 0, 1, "start");
      step(0, 0, 1, 0, 0, 0, 4, 0, 1, "os_4");
      step(0, 0, 1, 0, 0, 0, 3, 0, 1, "os_3");
      step(0, 0, 1, 0, 0, 0, 2, 0, 1, "os_2");
      step(0, 0, 1, 0, 0, 0, 1, 0, 1, "os_1");
      step(0, 0, 1, 0, 0, 0, 0, 0, 1, "os_0");
      step(0, 0, 1, 0, 0, 0, 5, 1, 0, "os_term");
      step(0, 0, 1, 0, 0, 0, 5, 0, 0, "os_idle1");
      step(0, 0, 1, 0, 0, 0, 5, 0, 0, "os_idle2");

      // auto-reload, period 6
      step(0, 1, 1, 0, 0, 1, 5, 0, 1, "ar_start");
      for (int i = 0; i < 12; i++) begin
         if (i % 6 == 5)
            step(0, 0, 1, 0, 0, 1, 5, 1, 1, "ar_term");
         else
            step(0, 0, 1, 0, 0, 1, 3'(4 - (i % 6)), 0, 1, "ar_cnt");
      end

      // en gating, start ignored in RUN
      step(0, 0, 1, 0, 0, 1, 4, 0, 1, "en_4");
      step(0, 1, 1, 0, 0, 1, 3, 0, 1, "en_3_start_ign");
      step(0, 0, 1, 0, 0, 1, 2, 0, 1, "en_t1");
      step(0, 0, 0, 0, 0, 1, 2, 0, 1, "en_t0");
      step(0, 0, 1, 0, 0, 1, 1, 0, 1, "en_t1b");
      step(0, 1, 0, 0, 0, 1, 1, 0, 1, "en_t0b");
      step(0, 0, 1, 0, 0, 1, 0, 0, 1, "en_0");
      step(0, 0, 1, 0, 0, 1, 5, 1, 1, "en_term");
      step(0, 0, 0, 0, 0, 1, 5, 0, 1, "done_no_hold");
      step(0, 0, 0, 0, 0, 1, 5, 0, 1, "hold_en0");

      // load overrides decrement
      step(0, 0, 1, 0, 0, 1, 4, 0, 1, "ld_pre");
      step(0, 0, 1, 1, 2, 1, 2, 0, 1, "ld_2");
      step(0, 0, 1, 0, 0, 1, 1, 0, 1, "ld_1");
      step(0, 0, 1, 0, 0, 1, 0, 0, 1, "ld_0");
      step(0, 0, 1, 0, 0, 1, 2, 1, 1, "ld_term");
      step(0, 0, 1, 0, 0, 1, 1, 0, 1, "ld_r1");
      step(0, 0, 1, 0, 0, 1, 0, 0, 1, "ld_r0");
      step(0, 0, 1, 0, 0, 1, 2, 1, 1, "ld_term2");

      // reload 0: done every cycle
      step(0, 0, 1, 1, 0, 1, 0, 0, 1, "ld0");
      for (int i = 0; i < 3; i++)
         step(0, 0, 1, 0, 0, 1, 0, 1, 1, "r0_term");

      // reload max: period 8
      step(0, 0, 1, 1, 7, 1, 7, 0, 1, "ld7");
      for (int i = 0; i < 16; i++) begin
         if (i % 8 == 7)
            step(0, 0, 1, 0, 0, 1, 7, 1, 1, "r7_term");
         else
            step(0, 0, 1, 0, 0, 1, 3'(6 - (i % 8)), 0, 1, "r7_cnt");
      end

      // reset aborts at out=1, no done pulse
      step(0, 0, 1, 1, 2, 1, 2, 0, 1, "rs_ld2");
      step(0, 0, 1, 0, 0, 1, 1, 0, 1, "rs_1");
      step(1, 0, 1, 0, 0, 1, 5, 0, 0, "rs_abort");
      step(0, 0, 1, 0, 0, 1, 5, 0, 0, "rs_idle");

      // load + start together in IDLE
      step(0, 1, 0, 1, 3, 0, 3, 0, 1, "ldst_3");
      step(0, 0, 1, 0, 0, 0, 2, 0, 1, "ldst_2");
      step(0, 0, 1, 0, 0, 0, 1, 0, 1, "ldst_1");
      step(0, 0, 1, 0, 0, 0, 0, 0, 1, "ldst_0");
      step(0, 0, 1, 0, 0, 0, 3, 1, 0, "ldst_term");
      step(0, 0, 1, 0, 0, 0, 3, 0, 0, "ldst_idle");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/modn_down_timer.md
Name: modN_down_timer

Overview:
Loadable mod-N down counter and timer, M-bit wide. It counts from a reload value down to 0 on enabled clocks, then emits a one-cycle terminal pulse. It either stops (one-shot) or reloads and continues (auto-reload). It is the count-down companion to the team's mod-N up counter and is used for timeouts, baud/tick dividers and delay generation in the same datapaths.

Parameters:
M, 3, counter and reload width in bits
N, 5, default reload value after reset (truncated to M bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable; a decrement happens only on cycles with en=1 while in RUN
start  input  1  launch countdown from IDLE; ignored in RUN
load  input  1  write load_val into the reload register and the counter
load_val  input  M  new reload value
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at terminal count
out  output  M  current count (registered)
done  output  1  registered one-cycle terminal-count pulse
busy  output  1  1 while in RUN state

Behaviour:
- Single clock domain. All outputs are registered. Reset is synchronous and active-high, and its priority is reset > load > start > count.
- Reset: out=N, reload_reg=N, done=0, busy=0, state=IDLE. Reset asserted mid-countdown aborts on that edge. No done pulse is produced.
- States are IDLE and RUN. busy=1 exactly when state=RUN.
- IDLE:
  - out holds its value.
  - en has no effect.
  - start=1 -> RUN next cycle. out is unchanged, so counting starts from the current out.
- RUN, en=0: out holds, done=0, state holds.
- RUN, en=1, out>0: out <= out-1, done <= 0.
- RUN, en=1, out==0 (terminal):
  - out <= reload_reg, done <= 1 for exactly one cycle.
  - If auto_reload=1, stay in RUN.
  - If auto_reload=0, go to IDLE (busy=0 next cycle).
- Period: with en held high and reload value R, done pulses every R+1 cycles. R=0 gives done every cycle in auto-reload mode.
- done is cleared on every edge that is not a terminal event, regardless of en. It never stretches.
- load=1, any state:
  - reload_reg <= load_val, out <= load_val, done <= 0.
  - Any terminal or decrement on that edge is suppressed.
  - State is unchanged, except load and start together in IDLE -> RUN with out=load_val.
- start=1 while in RUN: ignored.
- No underflow: out never decrements below 0. Arithmetic is M-bit unsigned.
- load_val may take any M-bit value, including 0 and 2^M-1.

Test Plan:
- Reset, then start, en=1 continuous, auto_reload=0, M=3, N=5 -> out 5,4,3,2,1,0, then done=1 with out=5 on the next edge, busy=0, and out stays 5 afterwards.
- auto_reload=1, en=1 continuous, N=5 -> done pulses every 6 cycles; busy stays 1; out sequence 5..0 repeats.
- en toggled 1,0,1,0 in RUN from out=3 -> out 2,2,1,1. done stays 0 throughout, and done is never held across en=0 after a terminal pulse.
- load=1, load_val=2 while RUN at out=4, in the same cycle as en=1 -> out=2, not 3. The following terminal reload gives out=2, and done fires after 3 enabled cycles.
- load_val=0 with auto_reload=1 and en=1 -> done=1 every cycle, out=0 constant. Also load_val=7 (max) -> period of 8.
- reset=1 asserted while RUN at out=1, on the cycle out would reach 0 -> next edge out=5, done=0, busy=0. No done pulse is ever seen.
